// File: rtl/noc_rx_endpoint.sv
// ---------------------------------------------------------------------------
// noc_rx_endpoint
//
// Processor-side receive endpoint for one node of the 2x2 mesh NoC.
// Takes flits from the router's local output and checks their destination.
// Flits addressed to this node go into a first-word-fall-through FIFO, which
// the processor drains with a valid/read handshake. rx_ready feeds this
// node's bit of processor_ready_signals.
//
// Optional build macro: NOC_RX_PARITY_EN
//   Defined   : payload[3] is an even-parity bit over rx_flit[7:0]. Correctly
//               routed flits with bad parity are discarded and counted on
//               parity_err_count.
//   Undefined : no parity check; all four payload bits are data.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-low reset
//   rx_flit[8:0]     in   [8] valid, [7:6] dest, [5:4] src, [3:0] payload
//   block_all_paths  in   global block; traffic refused while high
//   flush            in   one-cycle pulse; discards FIFO contents
//   rx_ready         out  endpoint can accept a flit this cycle
//   proc_valid       out  proc_data holds the head flit
//   proc_data[5:0]   out  head flit {src, payload}
//   proc_rd_en       in   pop head when proc_valid is high
//   fifo_count       out  current occupancy
//   overflow         out  sticky: valid flit arrived while full, no pop
//   drop_count       out  saturating count of dropped flits
//   misroute_count   out  saturating count of misrouted flits
//   parity_err_count out  (NOC_RX_PARITY_EN only) saturating parity errors
// ---------------------------------------------------------------------------
module noc_rx_endpoint #(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [8:0]               rx_flit,
    input  logic                     block_all_paths,
    input  logic                     flush,
    output logic                     rx_ready,
    output logic                     proc_valid,
    output logic [5:0]               proc_data,
    input  logic                     proc_rd_en,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         misroute_count
`ifdef NOC_RX_PARITY_EN
    ,
    output logic [CNT_W-1:0]         parity_err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [1:0]       NODE_C  = 2'(NODE_ID);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_BLOCK, ST_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [5:0]        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     remain;
    logic [5:0]        data_q, data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  mis_q, mis_d;

    logic              flit_valid, dest_ok, in_run, full, parity_bad;
    logic              push, pop, ovf_hit, drop_hit, mis_hit;
    logic [5:0]        push_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // ---------------- state machine ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN: begin
                if (flush)                state_d = ST_FLUSH;
                else if (block_all_paths) state_d = ST_BLOCK;
            end
            ST_BLOCK: begin
                if (flush)                 state_d = ST_FLUSH;
                else if (!block_all_paths) state_d = ST_RUN;
            end
            ST_FLUSH: state_d = block_all_paths ? ST_BLOCK : ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    // ---------------- accept / drop decisions ----------------
    always_comb begin
        flit_valid = rx_flit[8];
        dest_ok    = (rx_flit[7:6] == NODE_C);
        in_run     = (state_q == ST_RUN);
        full       = (count_q == DEPTH_C);
        push_data  = rx_flit[5:0];
`ifdef NOC_RX_PARITY_EN
        parity_bad = ^rx_flit[7:0];
`else
        parity_bad = 1'b0;
`endif
        pop      = proc_rd_en && proc_valid &&
                   ((state_q == ST_RUN) || (state_q == ST_BLOCK));
        // A pop in the same cycle frees the slot a full FIFO needs.
        push     = in_run && flit_valid && dest_ok && !parity_bad && (!full || pop);
        ovf_hit  = in_run && flit_valid && dest_ok && !parity_bad && full && !pop;
        mis_hit  = in_run && flit_valid && !dest_ok;
        // Outside RUN every valid flit is a drop, misrouted or not.
        drop_hit = (flit_valid && !in_run) || ovf_hit;
    end

    // ---------------- FIFO bookkeeping ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        remain   = count_q - CW'(pop);
        // Clearing on entry makes the FLUSH cycle itself show an empty FIFO.
        if (state_d == ST_FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        // Head register: the pushed flit bypasses memory when it becomes the
        // head immediately; otherwise read the entry at the new read pointer.
        // The value is held while the FIFO is empty.
        data_d = data_q;
        if (count_d != '0) begin
            data_d = (remain == '0) ? push_data : mem_q[rd_ptr_d];
        end
        rx_ready_d = (state_d == ST_RUN) && (count_d < DEPTH_C);
        overflow_d = overflow_q || ovf_hit;
        drop_d     = sat_inc(drop_q, drop_hit);
        mis_d      = sat_inc(mis_q, mis_hit);
    end

    always_ff @(posedge clock) begin
        if (push && reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            rx_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            mis_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            rx_ready_q <= rx_ready_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            mis_q      <= mis_d;
        end
    end

`ifdef NOC_RX_PARITY_EN
    logic [CNT_W-1:0] perr_q, perr_d;
    logic             perr_hit;

    always_comb begin
        perr_hit = in_run && flit_valid && dest_ok && parity_bad;
        perr_d   = sat_inc(perr_q, perr_hit);
    end

    always_ff @(posedge clock) begin
        if (!reset) perr_q <= '0;
        else        perr_q <= perr_d;
    end

    assign parity_err_count = perr_q;
`endif

    assign rx_ready       = rx_ready_q;
    assign proc_valid     = (count_q != '0);
    assign proc_data      = data_q;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;
    assign drop_count     = drop_q;
    assign misroute_count = mis_q;

endmodule
